muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit that owns the architectural HI/LO registers. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO under a start/busy/done handshake, so the single-cycle ALU datapath never holds a wide multiplier or divider. It sits beside the ALU in EX. The pipeline stalls on busy and reads hi/lo directly for MFHI/MFLO.

---
 rtl/muldiv_pkg.sv | 38 +++
 rtl/muldiv_step.sv | 41 ++++
 rtl/muldiv_unit.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state constants and two's-complement helpers for the
// iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Helpers work on a wide container so one copy serves both WIDTH and 2*WIDTH.
    localparam int MAX_W = 128;

    function automatic logic [MAX_W-1:0] neg_w(input logic [MAX_W-1:0] x, input int w);
        logic [MAX_W-1:0] mask;
        if (w >= MAX_W) begin
            mask = {MAX_W{1'b1}};
        end else begin
            mask = (MAX_W'(1'b1) << w) - MAX_W'(1'b1);
        end
        return (~x + MAX_W'(1'b1)) & mask;
    endfunction

    function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] x, input int w);
        logic sign;
        sign = |(x & (MAX_W'(1'b1) << (w - 1)));
        return sign ? neg_w(x, w) : x;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply (mode=0) or restoring divide (mode=1)
// over the {acc, sreg} double-width working register.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] sreg,
    input  logic [WIDTH-1:0] opnd,
    input  logic             mode,
    output logic [WIDTH-1:0] acc_nxt,
    output logic [WIDTH-1:0] sreg_nxt
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH-1:0] diff_s;
    logic             borrow_s;

    // Multiply shifts the product right; divide shifts the dividend left into acc.
    always_comb begin
        sum_s    = {1'b0, acc} + {1'b0, opnd};
        rem_sh_s = {acc, sreg[WIDTH-1]};
        borrow_s = rem_sh_s < {1'b0, opnd};
        // When no borrow the true difference is below opnd, so WIDTH bits suffice.
        diff_s   = rem_sh_s[WIDTH-1:0] - opnd;
        if (mode) begin
            if (borrow_s) begin
                acc_nxt  = rem_sh_s[WIDTH-1:0];
                sreg_nxt = {sreg[WIDTH-2:0], 1'b0};
            end else begin
                acc_nxt  = diff_s;
                sreg_nxt = {sreg[WIDTH-2:0], 1'b1};
            end
        end else if (sreg[0]) begin
            {acc_nxt, sreg_nxt} = {sum_s, sreg[WIDTH-1:1]};
        end else begin
            {acc_nxt, sreg_nxt} = {1'b0, acc, sreg[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning HI/LO.
// Define MULDIV_FAST_MUL_EN for a single-cycle registered multiplier.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    import muldiv_pkg::*;

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int DW    = 2 * WIDTH;

    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] acc_r, sreg_r, opnd_r, hi_r, lo_r;
    logic             is_div_r, neg_res_r, neg_rem_r, dbz_op_r;
    logic             busy_r, done_r, dbz_r;

    logic             sgn_op_s;
    logic [WIDTH-1:0] a_mag_s, b_mag_s;
    logic [WIDTH-1:0] acc_nxt_s, sreg_nxt_s;
    logic [DW-1:0]    prod_raw_s, prod_fix_s;
    logic [WIDTH-1:0] quo_fix_s, rem_fix_s, hi_fix_s, lo_fix_s;

    function automatic logic [WIDTH-1:0] abs_op(input logic [WIDTH-1:0] x);
        return WIDTH'(abs_w(MAX_W'(x), WIDTH));
    endfunction

    function automatic logic [WIDTH-1:0] neg_op(input logic [WIDTH-1:0] x);
        return WIDTH'(neg_w(MAX_W'(x), WIDTH));
    endfunction

    function automatic logic [DW-1:0] neg_dbl(input logic [DW-1:0] x);
        return DW'(neg_w(MAX_W'(x), DW));
    endfunction

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_r),
        .sreg     (sreg_r),
        .opnd     (opnd_r),
        .mode     (is_div_r),
        .acc_nxt  (acc_nxt_s),
        .sreg_nxt (sreg_nxt_s)
    );

    // Operand magnitudes presented to the core at accept time.
    always_comb begin
        sgn_op_s = (op == OP_MULT) || (op == OP_DIV);
        if (sgn_op_s) begin
            a_mag_s = abs_op(a);
            b_mag_s = abs_op(b);
        end else begin
            a_mag_s = a;
            b_mag_s = b;
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [DW-1:0] fast_prod_s;
    assign fast_prod_s = DW'(a_mag_s) * DW'(b_mag_s);
`endif

    // Sign correction of the unsigned core result, consumed in FIX.
    always_comb begin
        prod_raw_s = {acc_r, sreg_r};
        prod_fix_s = neg_res_r ? neg_dbl(prod_raw_s) : prod_raw_s;
        quo_fix_s  = neg_res_r ? neg_op(sreg_r) : sreg_r;
        rem_fix_s  = neg_rem_r ? neg_op(acc_r) : acc_r;
        if (!is_div_r) begin
            hi_fix_s = prod_fix_s[DW-1:WIDTH];
            lo_fix_s = prod_fix_s[WIDTH-1:0];
        end else if (dbz_op_r) begin
            // Remainder path already restores the raw dividend; only lo is forced.
            hi_fix_s = rem_fix_s;
            lo_fix_s = {WIDTH{1'b1}};
        end else begin
            hi_fix_s = rem_fix_s;
            lo_fix_s = quo_fix_s;
        end
    end

    // Control FSM, working registers and architectural HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            acc_r     <= {WIDTH{1'b0}};
            sreg_r    <= {WIDTH{1'b0}};
            opnd_r    <= {WIDTH{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            is_div_r  <= 1'b0;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            dbz_op_r  <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            dbz_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    if (start) begin
                        case (op)
                            OP_MTHI: begin
                                hi_r    <= a;
                                done_r  <= 1'b1;
                                state_r <= ST_DONE;
                            end
                            OP_MTLO: begin
                                lo_r    <= a;
                                done_r  <= 1'b1;
                                state_r <= ST_DONE;
                            end
                            OP_MULT, OP_MULTU: begin
                                is_div_r  <= 1'b0;
                                neg_res_r <= sgn_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_rem_r <= 1'b0;
                                dbz_op_r  <= 1'b0;
                                busy_r    <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                                {acc_r, sreg_r} <= fast_prod_s;
                                state_r         <= ST_FIX;
`else
                                acc_r   <= {WIDTH{1'b0}};
                                sreg_r  <= b_mag_s;
                                opnd_r  <= a_mag_s;
                                cnt_r   <= CNT_W'(WIDTH);
                                state_r <= ST_RUN;
`endif
                            end
                            OP_DIV, OP_DIVU: begin
                                is_div_r  <= 1'b1;
                                neg_res_r <= sgn_op_s & (a[WIDTH-1] ^ b[WIDTH-1]);
                                neg_rem_r <= sgn_op_s & a[WIDTH-1];
                                dbz_op_r  <= (b == {WIDTH{1'b0}});
                                dbz_r     <= (b == {WIDTH{1'b0}});
                                acc_r     <= {WIDTH{1'b0}};
                                sreg_r    <= a_mag_s;
                                opnd_r    <= b_mag_s;
                                cnt_r     <= CNT_W'(WIDTH);
                                busy_r    <= 1'b1;
                                state_r   <= ST_RUN;
                            end
                            default: state_r <= ST_IDLE;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r <= ST_FIX;
                    end else begin
                        acc_r  <= acc_nxt_s;
                        sreg_r <= sreg_nxt_s;
                        cnt_r  <= cnt_r - CNT_W'(1'b1);
                    end
                end
                ST_FIX: begin
                    hi_r    <= hi_fix_s;
                    lo_r    <= lo_fix_s;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                    state_r <= ST_DONE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign hi          = hi_r;
    assign lo          = lo_r;
    assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vectors plus randomized ops
// checked against an arithmetic reference model of HI/LO and div_by_zero.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, div_by_zero;
    logic [W-1:0] hi, lo;

    int asserts = 0;
    int fails = 0;

    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;
    logic         m_dbz = 1'b0;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a, b, h, l;
        logic         dz;
    } vec_t;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input logic [2:0] o);
        if (o == OP_MTHI || o == OP_MTLO) return 0;
`ifdef MULDIV_FAST_MUL_EN
        if (o == OP_MULT || o == OP_MULTU) return 1;
`endif
        return W + 2;
    endfunction

    // Reference model: plain 64-bit arithmetic on the architectural result.
    task automatic model_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [63:0] p;
        longint sx, sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            OP_MULT:  begin p = sx * sy; m_hi = p[63:32]; m_lo = p[31:0]; end
            OP_MULTU: begin p = {32'd0, x} * {32'd0, y}; m_hi = p[63:32]; m_lo = p[31:0]; end
            OP_DIV, OP_DIVU: begin
                if (y == 0) begin
                    m_lo = '1; m_hi = x; m_dbz = 1'b1;
                end else begin
                    m_dbz = 1'b0;
                    if (o == OP_DIV) begin
                        p = sx / sy; m_lo = p[31:0];
                        p = sx % sy; m_hi = p[31:0];
                    end else begin
                        m_lo = x / y; m_hi = x % y;
                    end
                end
            end
            OP_MTHI: m_hi = x;
            OP_MTLO: m_lo = x;
            default: ;
        endcase
    endtask

    task automatic do_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output bit busy_err);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        busy_err = 1'b0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) busy_err = 1'b1;
            tick();
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        else if (busy !== 1'b0) busy_err = 1'b1;
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'h0000_0001;
            4: v = $urandom_range(0, 20);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    task automatic test_reset();
        asserts += 5;
        if (hi !== 32'd0)         begin fails++; $display("FAIL reset_hi: got %h want 0", hi); end
        if (lo !== 32'd0)         begin fails++; $display("FAIL reset_lo: got %h want 0", lo); end
        if (busy !== 1'b0)        begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (done !== 1'b0)        begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        if (div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    endtask

    task automatic test_directed();
        vec_t v[9];
        int lat;
        bit berr;
        v[0] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        v[1] = '{OP_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        v[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        v[3] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        v[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        v[5] = '{OP_DIVU,  32'd10,        32'd0,         32'h0000_000A, 32'hFFFF_FFFF, 1'b1};
        v[6] = '{OP_MULTU, 32'd6,         32'd7,         32'h0000_0000, 32'd42,        1'b1};
        v[7] = '{OP_DIVU,  32'd10,        32'd3,         32'h0000_0001, 32'h0000_0003, 1'b0};
        v[8] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        for (int i = 0; i < 9; i++) begin
            do_op(v[i].op, v[i].a, v[i].b, lat, berr);
            model_op(v[i].op, v[i].a, v[i].b);
            asserts += 5;
            if (lat !== exp_lat(v[i].op)) begin fails++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat(v[i].op)); end
            if (berr !== 1'b0)            begin fails++; $display("FAIL dir%0d_busy: busy profile wrong", i); end
            if (hi !== v[i].h)            begin fails++; $display("FAIL dir%0d_hi: got %h want %h", i, hi, v[i].h); end
            if (lo !== v[i].l)            begin fails++; $display("FAIL dir%0d_lo: got %h want %h", i, lo, v[i].l); end
            if (div_by_zero !== v[i].dz)  begin fails++; $display("FAIL dir%0d_dbz: got %b want %b", i, div_by_zero, v[i].dz); end
        end
    endtask

    task automatic test_random();
        int lat;
        bit berr;
        logic [2:0] o;
        logic [W-1:0] x, y;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 5));
            x = pick();
            y = pick();
            do_op(o, x, y, lat, berr);
            model_op(o, x, y);
            asserts += 5;
            if (lat !== exp_lat(o))     begin fails++; $display("FAIL rnd%0d_latency op%0d: got %0d want %0d", i, o, lat, exp_lat(o)); end
            if (berr !== 1'b0)          begin fails++; $display("FAIL rnd%0d_busy op%0d: busy profile wrong", i, o); end
            if (hi !== m_hi)            begin fails++; $display("FAIL rnd%0d_hi op%0d a=%h b=%h: got %h want %h", i, o, x, y, hi, m_hi); end
            if (lo !== m_lo)            begin fails++; $display("FAIL rnd%0d_lo op%0d a=%h b=%h: got %h want %h", i, o, x, y, lo, m_lo); end
            if (div_by_zero !== m_dbz)  begin fails++; $display("FAIL rnd%0d_dbz op%0d: got %b want %b", i, o, div_by_zero, m_dbz); end
        end
    endtask

    task automatic test_reserved();
        bit seen;
        tick();
        seen = 1'b0;
        op = 3'd6; a = 32'h1111_1111; b = 32'h2222_2222; start = 1'b1;
        tick();
        op = 3'd7;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            tick();
        end
        asserts += 3;
        if (seen !== 1'b0) begin fails++; $display("FAIL reserved_ignored: done/busy activity seen"); end
        if (hi !== m_hi)   begin fails++; $display("FAIL reserved_hi: got %h want %h", hi, m_hi); end
        if (lo !== m_lo)   begin fails++; $display("FAIL reserved_lo: got %h want %h", lo, m_lo); end
    endtask

    task automatic test_busy_ignore();
        int lat;
        bit berr;
        do_op(OP_MTHI, 32'h5555, 32'd0, lat, berr);
        model_op(OP_MTHI, 32'h5555, 32'd0);
        asserts += 2;
        if (lat !== 0)          begin fails++; $display("FAIL mthi_latency: got %0d want 0", lat); end
        if (hi !== 32'h5555)    begin fails++; $display("FAIL mthi_hi: got %h want 00005555", hi); end
        op = OP_DIVU; a = 32'd84; b = 32'd2; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        repeat (4) begin tick(); lat++; end
        op = OP_MTHI; a = 32'h1234; start = 1'b1;
        tick();
        lat++;
        start = 1'b0;
        asserts += 3;
        if (hi !== 32'h5555) begin fails++; $display("FAIL busy_mthi_hi: got %h want 00005555", hi); end
        if (done !== 1'b0)   begin fails++; $display("FAIL busy_mthi_done: got %b want 0", done); end
        if (busy !== 1'b1)   begin fails++; $display("FAIL busy_mthi_busy: got %b want 1", busy); end
        while (done !== 1'b1 && lat < 100) begin tick(); lat++; end
        model_op(OP_DIVU, 32'd84, 32'd2);
        asserts += 3;
        if (lat !== W + 2) begin fails++; $display("FAIL busy_div_latency: got %0d want %0d", lat, W + 2); end
        if (hi !== 32'd0)  begin fails++; $display("FAIL busy_div_hi: got %h want 0", hi); end
        if (lo !== 32'd42) begin fails++; $display("FAIL busy_div_lo: got %h want 0000002a", lo); end
        tick();
        do_op(OP_MTLO, 32'hABCD, 32'd0, lat, berr);
        model_op(OP_MTLO, 32'hABCD, 32'd0);
        asserts += 3;
        if (lat !== 0)         begin fails++; $display("FAIL mtlo_latency: got %0d want 0", lat); end
        if (berr !== 1'b0)     begin fails++; $display("FAIL mtlo_busy: busy raised"); end
        if (lo !== 32'hABCD)   begin fails++; $display("FAIL mtlo_lo: got %h want 0000abcd", lo); end
        tick();
        asserts += 1;
        if (done !== 1'b0) begin fails++; $display("FAIL mtlo_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_reset_abort_back_to_back();
        int lat;
        bit berr, seen;
        op = OP_DIVU; a = 32'd100; b = 32'd0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        asserts += 1;
        if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy_before: got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        asserts += 5;
        if (hi !== 32'd0)         begin fails++; $display("FAIL abort_hi: got %h want 0", hi); end
        if (lo !== 32'd0)         begin fails++; $display("FAIL abort_lo: got %h want 0", lo); end
        if (busy !== 1'b0)        begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
        if (done !== 1'b0)        begin fails++; $display("FAIL abort_done: got %b want 0", done); end
        if (div_by_zero !== 1'b0) begin fails++; $display("FAIL abort_dbz: got %b want 0", div_by_zero); end
        m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) seen = 1'b1;
            tick();
        end
        asserts += 1;
        if (seen !== 1'b0) begin fails++; $display("FAIL abort_no_done: aborted op produced done"); end
        do_op(OP_DIVU, 32'd100, 32'd7, lat, berr);
        model_op(OP_DIVU, 32'd100, 32'd7);
        asserts += 3;
        if (lat !== W + 2) begin fails++; $display("FAIL post_reset_latency: got %0d want %0d", lat, W + 2); end
        if (lo !== 32'd14) begin fails++; $display("FAIL post_reset_lo: got %h want 0000000e", lo); end
        if (hi !== 32'd2)  begin fails++; $display("FAIL post_reset_hi: got %h want 00000002", hi); end
        do_op(OP_MULTU, 32'd6, 32'd7, lat, berr);
        model_op(OP_MULTU, 32'd6, 32'd7);
        asserts += 4;
        if (lat !== exp_lat(OP_MULTU)) begin fails++; $display("FAIL b2b_latency: got %0d want %0d", lat, exp_lat(OP_MULTU)); end
        if (berr !== 1'b0)             begin fails++; $display("FAIL b2b_busy: busy profile wrong"); end
        if (lo !== 32'd42)             begin fails++; $display("FAIL b2b_lo: got %h want 0000002a", lo); end
        if (hi !== 32'd0)              begin fails++; $display("FAIL b2b_hi: got %h want 0", hi); end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        test_reset();
        rst_n = 1'b1;
        tick();
        test_directed();
        test_random();
        test_reserved();
        test_busy_ignore();
        test_reset_abort_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
